// File: rtl/jleightcap_seq.sv
// Instruction sequencer: stores up to DEPTH instructions and replays them into the core.
// Latency: start sampled on cycle N -> first entry on instr_out at N+1; then one entry every div+1 cycles.
// Backpressure: ld_ready drops while running, when full, or when clear/start is asserted; instr_out is never stalled.
module jleightcap_seq #(
  parameter int            DEPTH = 16,
  parameter int            AW    = 4,
  parameter int            IW    = 6,
  parameter logic [IW-1:0] NOP   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_instr,
  output logic          ld_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          halt,
  input  logic          loop,
  input  logic [3:0]    div,
  output logic [IW-1:0] instr_out,
  output logic          instr_vld,
  output logic          running,
  output logic          done,
  output logic [AW:0]   len
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);

  // Program store; contents deliberately survive reset and clear.
  logic [IW-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [3:0]    divcnt_q, divcnt_d;
  logic [3:0]    div_q, div_d;
  logic          loop_q, loop_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic          full;
  logic          ld_fire;
  logic          last_pc;
  logic [AW-1:0] pc_nxt;

  // pc_q always names the entry most recently issued during a run.
  assign full    = (len_q == LEN_FULL);
  assign last_pc = ({1'b0, pc_q} == (len_q - LEN_ONE));
  assign pc_nxt  = last_pc ? '0 : (pc_q + PC_ONE);

  // Loads are refused whenever clear or start would take priority this cycle.
  assign ld_ready = (state_q == S_IDLE) && !full && !start && !clear;
  assign ld_fire  = ld_valid && ld_ready;

  assign instr_out = instr_q;
  assign instr_vld = vld_q;
  assign running   = running_q;
  assign done      = done_q;
  assign len       = len_q;

  // Append accepted instructions at the current program length.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_q[len_q[AW-1:0]] <= ld_instr;
    end
  end

  // Next-state logic: IDLE handles clear > start > load, RUN paces issues by div.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pc_d     = pc_q;
    divcnt_d = divcnt_q;
    div_d    = div_q;
    loop_d   = loop_q;
    done_d   = done_q;
    instr_d  = NOP;
    vld_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          len_d  = '0;
          done_d = 1'b0;
        end else if (start && (len_q != '0)) begin
          // Entry 0 is issued on the start edge so it is visible one cycle later.
          loop_d   = loop;
          div_d    = div;
          pc_d     = '0;
          divcnt_d = '0;
          done_d   = 1'b0;
          state_d  = S_RUN;
          instr_d  = mem_q[0];
          vld_d    = 1'b1;
        end else if (ld_fire) begin
          len_d = len_q + LEN_ONE;
        end
      end

      S_RUN: begin
        if (halt) begin
          // Abort wins over normal completion; done is left as it was.
          state_d  = S_IDLE;
          pc_d     = '0;
          divcnt_d = '0;
        end else if (vld_q && last_pc && !loop_q) begin
          // Final entry is on the output now; finish without waiting out div.
          state_d  = S_IDLE;
          done_d   = 1'b1;
          pc_d     = '0;
          divcnt_d = '0;
        end else if (divcnt_q == div_q) begin
          divcnt_d = '0;
          pc_d     = pc_nxt;
          instr_d  = mem_q[pc_nxt];
          vld_d    = 1'b1;
        end else begin
          divcnt_d = divcnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      pc_q      <= '0;
      divcnt_q  <= '0;
      div_q     <= '0;
      loop_q    <= 1'b0;
      instr_q   <= NOP;
      vld_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      divcnt_q  <= divcnt_d;
      div_q     <= div_d;
      loop_q    <= loop_d;
      instr_q   <= instr_d;
      vld_q     <= vld_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_jleightcap_seq.sv
// Directed bench for jleightcap_seq: loading, paced replay, looping, halt, priority and reset.
module tb_jleightcap_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_valid = 1'b0;
  logic [5:0] ld_instr = '0;
  logic       ld_ready;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] div = '0;
  logic [5:0] instr_out;
  logic       instr_vld;
  logic       running;
  logic       done;
  logic [4:0] len;

  int errors = 0;
  int checks = 0;

  logic [5:0] prog3 [3];
  logic [5:0] prog16 [16];

  jleightcap_seq dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_instr  (ld_instr),
    .ld_ready  (ld_ready),
    .clear     (clear),
    .start     (start),
    .halt      (halt),
    .loop      (loop),
    .div       (div),
    .instr_out (instr_out),
    .instr_vld (instr_vld),
    .running   (running),
    .done      (done),
    .len       (len)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(input logic [5:0] v);
    ld_valid = 1'b1;
    ld_instr = v;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic run(input logic l, input logic [3:0] d);
    loop  = l;
    div   = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load3;
    do_clear();
    for (int i = 0; i < 3; i++) load(prog3[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({instr_out, instr_vld, running, done, len, ld_ready} !== {6'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset: instr=%h vld=%b run=%b done=%b len=%0d rdy=%b, want 00 0 0 0 0 1",
               instr_out, instr_vld, running, done, len, ld_ready);
    end
  endtask

  task automatic test_div0;
    logic [5:0] ei;
    logic       ev;
    load3();
    checks++;
    if (len !== 5'd3) begin
      errors++;
      $display("FAIL div0_len: got %0d want 3", len);
    end
    run(1'b0, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      ev = (c <= 3);
      ei = ev ? prog3[c-1] : 6'h00;
      checks++;
      if (instr_out !== ei || instr_vld !== ev || running !== ev) begin
        errors++;
        $display("FAIL div0_c%0d: instr=%h vld=%b run=%b want %h %b %b", c, instr_out, instr_vld, running, ei, ev, ev);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL div0_done: done=%b run=%b want 1 0", done, running);
    end
  endtask

  task automatic test_div2;
    logic [5:0] ei;
    logic       ev;
    run(1'b0, 4'd2);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL div2_done_clr: got %b want 0", done);
    end
    for (int c = 1; c <= 10; c++) begin
      ev = (c == 1 || c == 4 || c == 7);
      ei = (c == 1) ? prog3[0] : (c == 4) ? prog3[1] : (c == 7) ? prog3[2] : 6'h00;
      checks++;
      if (instr_out !== ei || instr_vld !== ev) begin
        errors++;
        $display("FAIL div2_c%0d: instr=%h vld=%b want %h %b", c, instr_out, instr_vld, ei, ev);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL div2_done: done=%b run=%b want 1 0", done, running);
    end
  endtask

  task automatic test_full;
    do_clear();
    for (int i = 0; i < 16; i++) load(prog16[i]);
    checks++;
    if (len !== 5'd16 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: len=%0d rdy=%b want 16 0", len, ld_ready);
    end
    load(6'h2A);
    checks++;
    if (len !== 5'd16) begin
      errors++;
      $display("FAIL full_drop: len=%0d want 16", len);
    end
    run(1'b1, 4'd0);
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (instr_out !== prog16[(c-1)%16] || instr_vld !== 1'b1) begin
        errors++;
        $display("FAIL loop16_c%0d: instr=%h vld=%b want %h 1", c, instr_out, instr_vld, prog16[(c-1)%16]);
      end
      if (c == 20) halt = 1'b1;
      tick();
    end
    halt = 1'b0;
  endtask

  task automatic test_halt;
    run(1'b1, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (instr_out !== prog16[c-1] || instr_vld !== 1'b1) begin
        errors++;
        $display("FAIL halt_pre_c%0d: instr=%h vld=%b want %h 1", c, instr_out, instr_vld, prog16[c-1]);
      end
      if (c == 5) halt = 1'b1;
      tick();
    end
    halt = 1'b0;
    checks++;
    if ({instr_out, instr_vld, running, done} !== {6'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_after: instr=%h vld=%b run=%b done=%b want 00 0 0 0", instr_out, instr_vld, running, done);
    end
    // Restart replays from entry 0; halt on the final issue must leave done clear.
    run(1'b0, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (instr_out !== prog16[c-1] || instr_vld !== 1'b1) begin
        errors++;
        $display("FAIL restart_c%0d: instr=%h vld=%b want %h 1", c, instr_out, instr_vld, prog16[c-1]);
      end
      if (c == 16) halt = 1'b1;
      tick();
    end
    halt = 1'b0;
    checks++;
    if (done !== 1'b0 || running !== 1'b0 || instr_vld !== 1'b0) begin
      errors++;
      $display("FAIL halt_last: done=%b run=%b vld=%b want 0 0 0", done, running, instr_vld);
    end
  endtask

  task automatic test_priority;
    do_clear();
    run(1'b0, 4'd0);
    checks++;
    if (running !== 1'b0 || instr_vld !== 1'b0) begin
      errors++;
      $display("FAIL start_empty: run=%b vld=%b want 0 0", running, instr_vld);
    end
    load(6'h05);
    load(6'h0A);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (len !== 5'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: len=%0d run=%b want 0 0", len, running);
    end
    load(6'h05);
    load(6'h0A);
    ld_valid = 1'b1;
    ld_instr = 6'h11;
    run(1'b0, 4'd0);
    checks++;
    if (running !== 1'b1 || len !== 5'd2 || instr_out !== 6'h05 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_load: run=%b len=%0d instr=%h rdy=%b want 1 2 05 0", running, len, instr_out, ld_ready);
    end
    tick();
    ld_valid = 1'b0;
    checks++;
    if (instr_out !== 6'h0A || instr_vld !== 1'b1 || len !== 5'd2) begin
      errors++;
      $display("FAIL start_load_2: instr=%h vld=%b len=%0d want 0A 1 2", instr_out, instr_vld, len);
    end
    tick();
    checks++;
    if (instr_vld !== 1'b0 || done !== 1'b1 || len !== 5'd2) begin
      errors++;
      $display("FAIL start_load_end: vld=%b done=%b len=%0d want 0 1 2", instr_vld, done, len);
    end
  endtask

  task automatic test_back_to_back;
    do_clear();
    load(6'h15);
    run(1'b1, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (instr_out !== 6'h15 || instr_vld !== 1'b1) begin
        errors++;
        $display("FAIL len1_c%0d: instr=%h vld=%b want 15 1", c, instr_out, instr_vld);
      end
      tick();
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic test_rst_mid;
    load3();
    run(1'b1, 4'd0);
    tick();
    checks++;
    if (instr_out !== 6'h0A || instr_vld !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: instr=%h vld=%b want 0A 1", instr_out, instr_vld);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({instr_out, instr_vld, len, running, done} !== {6'h00, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: instr=%h vld=%b len=%0d run=%b done=%b want 00 0 0 0 0",
               instr_out, instr_vld, len, running, done);
    end
  endtask

  initial begin
    prog3[0] = 6'h05;
    prog3[1] = 6'h0A;
    prog3[2] = 6'h3F;
    for (int i = 0; i < 16; i++) prog16[i] = 6'((i * 5 + 3) % 64);
    test_reset();
    test_div0();
    test_div2();
    test_full();
    test_halt();
    test_priority();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
